led_matrix_frame_capture: RTL and testbench

- Receiving end of the 8x8 RGB LED-matrix serial interface: reset_out, OE, SH_CP, ST_CP, DS, col_select.
- Models the shift-register chain in logic. Rebuilds the column data driven by the game/display block into an internal 8-column frame buffer.
- Exposes the buffer through a registered readback port, with frame-complete and protocol-error status.
- Used for on-board self-check and simulation scoreboarding of the display path.

---
 rtl/led_matrix_frame_capture.sv | 154 +++++++++++++++
 tb/tb_led_matrix_frame_capture.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_frame_capture.sv
// ============================================================================
// led_matrix_frame_capture : rebuilds 8x8 RGB LED-matrix column frames from the
//                            serial display pins (74HC595-style chain model)
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_matrix_frame_capture #(
  parameter int SHIFT_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sr_reset_n,
  input  logic                  oe_n,
  input  logic                  sh_cp,
  input  logic                  st_cp,
  input  logic                  ds,
  input  logic [7:0]            col_select,
  input  logic [2:0]            rd_col,
  output logic [SHIFT_BITS-1:0] rd_data,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  blank,
  output logic                  err_bitcount,
  output logic                  err_col,
  input  logic                  err_clear
);

  localparam int         PINS     = 13;
  localparam logic [PINS-1:0] SYNC_RST = 13'h002;  // oe_n idles high so blank resets to 1
  localparam logic [7:0] CNT_MAX  = 8'd255;

  logic [PINS-1:0]       sync_q [SYNC_STAGES];
  logic                  sh_hist_q, st_hist_q;
  logic [SHIFT_BITS-1:0] shift_q, shift_d;
  logic [SHIFT_BITS-1:0] storage_q, storage_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  wr_pend_q;
  logic [7:0]            mask_q, mask_d;
  logic [SHIFT_BITS-1:0] frame_q [8];
  logic [SHIFT_BITS-1:0] rd_data_q;
  logic                  done_q, done_d;
  logic [15:0]           count_q, count_d;
  logic                  err_bc_q, err_bc_d;
  logic                  err_col_q, err_col_d;

  logic                  srn_s, oe_s, sh_s, st_s, ds_s;
  logic [7:0]            col_s;
  logic                  sh_rise, st_rise;
  logic                  bc_set, col_set, col_onehot, wr_en;
  logic [2:0]            col_idx;
  logic [7:0]            mask_nxt;

  assign {col_s, ds_s, st_s, sh_s, oe_s, srn_s} = sync_q[SYNC_STAGES-1];
  assign sh_rise = sh_s & ~sh_hist_q;
  assign st_rise = st_s & ~st_hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      sh_hist_q <= 1'b0;
      st_hist_q <= 1'b0;
    end else begin
      sync_q[0] <= {col_select, ds, st_cp, sh_cp, oe_n, sr_reset_n};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sh_hist_q <= sh_s;
      st_hist_q <= st_s;
    end
  end

  // Latch samples the pre-shift chain; a coincident shift still happens afterwards.
  always_comb begin
    shift_d   = shift_q;
    storage_d = storage_q;
    cnt_d     = cnt_q;
    bc_set    = 1'b0;
    if (st_rise) begin
      storage_d = shift_q;
      bc_set    = (cnt_q != 8'(SHIFT_BITS));
      cnt_d     = 8'd0;
    end
    if (!srn_s) begin
      shift_d = '0;
      cnt_d   = 8'd0;
    end else if (sh_rise) begin
      shift_d = {shift_q[SHIFT_BITS-2:0], ds_s};
      cnt_d   = (cnt_d == CNT_MAX) ? CNT_MAX : cnt_d + 8'd1;
    end
  end

  always_comb begin
    col_onehot = (col_s != 8'd0) && ((col_s & (col_s - 8'd1)) == 8'd0);
    col_idx    = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (col_s[k]) col_idx = 3'(k);
    end
    wr_en    = wr_pend_q & col_onehot;
    col_set  = wr_pend_q & ~col_onehot;
    mask_nxt = mask_q | (8'd1 << col_idx);
    mask_d   = mask_q;
    done_d   = 1'b0;
    count_d  = count_q;
    if (wr_en) begin
      if (mask_nxt == 8'hFF) begin
        mask_d  = 8'h00;
        done_d  = 1'b1;
        count_d = count_q + 16'd1;
      end else begin
        mask_d  = mask_nxt;
      end
    end
    err_bc_d  = bc_set  | (err_bc_q  & ~err_clear);
    err_col_d = col_set | (err_col_q & ~err_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      storage_q <= '0;
      cnt_q     <= 8'd0;
      wr_pend_q <= 1'b0;
      mask_q    <= 8'h00;
      for (int i = 0; i < 8; i++) frame_q[i] <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      count_q   <= 16'd0;
      err_bc_q  <= 1'b0;
      err_col_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      storage_q <= storage_d;
      cnt_q     <= cnt_d;
      wr_pend_q <= st_rise;
      mask_q    <= mask_d;
      if (wr_en) frame_q[col_idx] <= storage_q;
      rd_data_q <= frame_q[rd_col];
      done_q    <= done_d;
      count_q   <= count_d;
      err_bc_q  <= err_bc_d;
      err_col_q <= err_col_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign frame_done   = done_q;
  assign frame_count  = count_q;
  assign blank        = oe_s;
  assign err_bitcount = err_bc_q;
  assign err_col      = err_col_q;

endmodule

`default_nettype wire

// File: tb/tb_led_matrix_frame_capture.sv
// ============================================================================
// tb_led_matrix_frame_capture : directed plus random pin-level stimulus against
//                               a frame-level reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_matrix_frame_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sr_reset_n = 1'b1;
  logic        oe_n = 1'b1;
  logic        sh_cp = 1'b0;
  logic        st_cp = 1'b0;
  logic        ds = 1'b0;
  logic [7:0]  col_select = 8'h00;
  logic [2:0]  rd_col = 3'd0;
  logic        err_clear = 1'b0;
  logic [23:0] rd_data;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        blank;
  logic        err_bitcount;
  logic        err_col;

  led_matrix_frame_capture #(.SHIFT_BITS(24), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sr_reset_n(sr_reset_n), .oe_n(oe_n),
    .sh_cp(sh_cp), .st_cp(st_cp), .ds(ds), .col_select(col_select),
    .rd_col(rd_col), .rd_data(rd_data), .frame_done(frame_done),
    .frame_count(frame_count), .blank(blank), .err_bitcount(err_bitcount),
    .err_col(err_col), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int dut_done = 0;

  // Reference model: the display chain as seen from the frame level.
  logic [23:0] m_sr;
  logic [23:0] m_frame [8];
  int          m_cnt;
  logic [7:0]  m_mask;
  int          m_fc;
  logic        m_ebc, m_ecol, m_oe;
  int          m_done;

  always @(negedge clk) if (frame_done === 1'b1) dut_done++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear_all();
    m_sr = '0; m_cnt = 0; m_mask = '0; m_fc = 0; m_ebc = 0; m_ecol = 0;
    for (int i = 0; i < 8; i++) m_frame[i] = '0;
  endtask

  task automatic m_shift(input logic b);
    m_sr = {m_sr[22:0], b};
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic m_latch(input logic [7:0] col);
    if (m_cnt != 24) m_ebc = 1'b1;
    m_cnt = 0;
    if ($countones(col) == 1) begin
      for (int k = 0; k < 8; k++) begin
        if (col[k]) begin
          m_frame[k] = m_sr;
          m_mask[k]  = 1'b1;
        end
      end
      if (m_mask == 8'hFF) begin
        m_mask = 8'h00;
        m_done++;
        m_fc = (m_fc + 1) % 65536;
      end
    end else begin
      m_ecol = 1'b1;
    end
  endtask

  task automatic p_shift(input logic b);
    ds = b; cyc(3);
    sh_cp = 1'b1; m_shift(b); cyc(3);
    sh_cp = 1'b0;
  endtask

  task automatic p_latch(input logic [7:0] col);
    col_select = col; cyc(3);
    st_cp = 1'b1; m_latch(col); cyc(4);
    st_cp = 1'b0; cyc(3);
  endtask

  task automatic p_word(input logic [23:0] v, input logic [7:0] col);
    for (int i = 23; i >= 0; i--) p_shift(v[i]);
    p_latch(col);
  endtask

  task automatic p_both(input logic b, input logic [7:0] col);
    ds = b; col_select = col; cyc(3);
    sh_cp = 1'b1; st_cp = 1'b1;
    m_latch(col); m_shift(b);
    cyc(4);
    sh_cp = 1'b0; st_cp = 1'b0; cyc(3);
  endtask

  task automatic p_srrst();
    sr_reset_n = 1'b0; m_sr = '0; m_cnt = 0; cyc(5);
    sr_reset_n = 1'b1; cyc(3);
  endtask

  task automatic p_clear();
    cyc(6);
    err_clear = 1'b1; m_ebc = 0; m_ecol = 0; cyc(1);
    err_clear = 1'b0;
  endtask

  task automatic p_reset();
    reset = 1'b1; cyc(3);
    reset = 1'b0; m_clear_all(); cyc(4);
  endtask

  task automatic check_all(input string tag);
    cyc(8);
    for (int c = 0; c < 8; c++) begin
      rd_col = 3'(c); cyc(1);
      chk($sformatf("%s rd_data[%0d]", tag, c), 32'(rd_data), 32'(m_frame[c]));
    end
    chk({tag, " frame_count"}, 32'(frame_count), 32'(m_fc));
    chk({tag, " err_bitcount"}, 32'(err_bitcount), 32'(m_ebc));
    chk({tag, " err_col"}, 32'(err_col), 32'(m_ecol));
    chk({tag, " blank"}, 32'(blank), 32'(m_oe));
    chk({tag, " done_pulses"}, 32'(dut_done), 32'(m_done));
  endtask

  initial begin
    logic [23:0] v;
    logic [7:0]  col;
    int          r, n;

    m_clear_all(); m_oe = 1'b1; m_done = 0;

    cyc(3);
    chk("reset rd_data", 32'(rd_data), 32'h0);
    chk("reset frame_done", 32'(frame_done), 32'h0);
    chk("reset frame_count", 32'(frame_count), 32'h0);
    chk("reset blank", 32'(blank), 32'h1);
    chk("reset err_bitcount", 32'(err_bitcount), 32'h0);
    chk("reset err_col", 32'(err_col), 32'h0);
    reset = 1'b0; cyc(4);

    p_word(24'hA5C3F0, 8'h04);
    check_all("t1");
    chk("t1 col2 literal", 32'(m_frame[2]), 32'h00A5C3F0);

    p_latch(8'h06);
    p_latch(8'h00);
    check_all("t2");
    p_clear();
    check_all("t2clr");

    for (int i = 19; i >= 0; i--) p_shift(1'(i % 3 == 0));
    p_latch(8'h01);
    check_all("t3");
    p_clear();

    for (int i = 23; i >= 0; i--) p_shift(i == 0);
    p_both(1'b1, 8'h20);
    check_all("t4");
    for (int i = 0; i < 23; i++) p_shift(1'b0);
    p_latch(8'h40);
    check_all("t4cnt");

    for (int c = 0; c < 8; c++) p_word(24'(c + 1), 8'(1 << c));
    check_all("t5");
    for (int i = 0; i < 7; i++) p_word(24'h300 + 24'(i), 8'h08);
    check_all("t5rw");

    for (int i = 0; i < 10; i++) p_shift(1'b1);
    p_srrst();
    p_word(24'h123456, 8'h01);
    check_all("t6");
    for (int c = 1; c < 6; c++) p_word(24'h00BEEF + 24'(c), 8'(1 << c));
    p_reset();
    check_all("t6rst");
    for (int c = 0; c < 7; c++) p_word(24'h777000 + 24'(c), 8'(1 << c));
    check_all("t6post");

    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        v = 24'($urandom);
        col = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
        p_word(v, col);
      end else if (r == 5) begin
        n = $urandom_range(1, 30);
        for (int i = 0; i < n; i++) p_shift(1'($urandom));
        p_latch(8'(1 << $urandom_range(0, 7)));
      end else if (r == 6) begin
        p_both(1'($urandom), 8'(1 << $urandom_range(0, 7)));
      end else if (r == 7) begin
        p_srrst();
      end else if (r == 8) begin
        oe_n = ~oe_n; m_oe = oe_n;
      end else begin
        p_clear();
      end
      check_all($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
